// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads two bytes (low byte first) from a byte-wide
// memory at the address held in an external 16-bit PC register, assembles
// them into a 16-bit instruction, and holds it until the consumer accepts it.
// PC clear/jump requests are handled here only while idle.
module instruction_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pc_clr,
  input  logic        jump_en,
  input  logic [15:0] jump_addr,
  input  logic [15:0] pc_q,
  output logic        pc_e,
  output logic [1:0]  pc_funsel,
  output logic [15:0] pc_i,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ_LO = 2'b01,
    REQ_HI = 2'b10,
    HOLD   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    FS_DEC  = 2'b00,
    FS_INC  = 2'b01,
    FS_LOAD = 2'b10,
    FS_CLR  = 2'b11
  } funsel_e;

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  funsel_e     funsel;

  // State and instruction registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs; the instruction register is reset so a
  // fetch abandoned by reset leaves no partial byte behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      instr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // Next-state, byte capture and PC-register control.
  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a value held (no latches).
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    pc_e        = 1'b0;
    funsel      = FS_DEC;
    pc_i        = 16'h0000;
    mem_req     = 1'b0;
    instr_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Clear beats jump, jump beats start; clear/jump never leave IDLE.
        if (pc_clr) begin
          pc_e   = 1'b1;
          funsel = FS_CLR;
        end else if (jump_en) begin
          pc_e   = 1'b1;
          funsel = FS_LOAD;
          pc_i   = jump_addr;
        end else if (start) begin
          state_d = REQ_LO;
        end
      end

      REQ_LO: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          pc_e         = 1'b1;
          funsel       = FS_INC;
          instr_d[7:0] = mem_rdata;
          state_d      = REQ_HI;
        end
      end

      REQ_HI: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          pc_e          = 1'b1;
          funsel        = FS_INC;
          instr_d[15:8] = mem_rdata;
          state_d       = HOLD;
        end
      end

      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          state_d = start ? REQ_LO : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // The PC controls come straight from inputs in IDLE, so reset must mask
    // them explicitly to keep the PC register untouched while rst is low.
    if (!rst) begin
      pc_e   = 1'b0;
      funsel = FS_DEC;
      pc_i   = 16'h0000;
    end
  end

  // Address is only meaningful during a request; otherwise held at zero.
  assign mem_addr  = mem_req ? pc_q : 16'h0000;
  assign pc_funsel = funsel;
  assign instr     = instr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: a behavioural PC register and byte memory
// surround the DUT; fetched words are checked through a scoreboard queue.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, pc_clr, jump_en;
  logic [15:0] jump_addr;
  logic [15:0] pc_q;
  logic        pc_e;
  logic [1:0]  pc_funsel;
  logic [15:0] pc_i;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pc_clr      (pc_clr),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .pc_q        (pc_q),
    .pc_e        (pc_e),
    .pc_funsel   (pc_funsel),
    .pc_i        (pc_i),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .busy        (busy)
  );

  // Downstream 16-bit PC register driven by the DUT's control outputs.
  logic [15:0] pc_reg = 16'h0000;
  assign pc_q = pc_reg;
  always @(posedge clk) begin
    if (pc_e) begin
      case (pc_funsel)
        2'b00:   pc_reg <= pc_reg - 16'd1;
        2'b01:   pc_reg <= pc_reg + 16'd1;
        2'b10:   pc_reg <= pc_i;
        default: pc_reg <= 16'h0000;
      endcase
    end
  end

  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_pc;

  // Byte memory contents: two fixed bytes, a simple pattern elsewhere.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    logic [7:0] lo, hi;
    lo = a[7:0];
    hi = a[15:8];
    case (a)
      16'h0010: return 8'h34;
      16'h0011: return 8'h12;
      default:  return (lo * 8'd3) + hi + 8'h11;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_idle();
    start       = 1'b0;
    pc_clr      = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = 16'h0000;
    mem_ack     = 1'b0;
    mem_rdata   = 8'h00;
    instr_ready = 1'b0;
  endtask

  task automatic push_expected();
    logic [15:0] a1;
    a1 = exp_pc + 16'd1;
    sb.push_back({mem_byte(a1), mem_byte(exp_pc)});
  endtask

  // One IDLE cycle with start high.
  task automatic start_cycle(input string name);
    cyc();
    set_idle();
    start = 1'b1;
    #1;
    check({name, "_start_pc_e"}, pc_e, 1'b0);
    check({name, "_start_busy"}, busy, 1'b0);
    push_expected();
  endtask

  // One IDLE cycle with nothing requested.
  task automatic idle_cycle(input string name);
    cyc();
    set_idle();
    #1;
    check({name, "_idle_busy"}, busy, 1'b0);
    check({name, "_idle_valid"}, instr_valid, 1'b0);
    check({name, "_idle_pc_e"}, pc_e, 1'b0);
    check({name, "_idle_pc"}, pc_reg, exp_pc);
  endtask

  // Starts in the first REQ_LO cycle; ends with the HOLD handshake cycle.
  // pc_clr/jump_en are driven high throughout to show they are ignored.
  task automatic run_word(input int waits, input int hold, input bit next_start,
                          input string name);
    for (int b = 0; b < 2; b++) begin
      for (int w = 0; w < waits; w++) begin
        cyc();
        start = 1'b0; instr_ready = 1'b0; mem_ack = 1'b0;
        pc_clr = 1'b1; jump_en = 1'b1; jump_addr = 16'hDEAD;
        #1;
        check({name, "_wait_req"}, mem_req, 1'b1);
        check({name, "_wait_addr"}, mem_addr, exp_pc);
        check({name, "_wait_pc_e"}, pc_e, 1'b0);
        check({name, "_wait_valid"}, instr_valid, 1'b0);
      end
      cyc();
      start = 1'b0; instr_ready = 1'b0;
      pc_clr = 1'b1; jump_en = 1'b1; jump_addr = 16'hDEAD;
      mem_ack = 1'b1; mem_rdata = mem_byte(exp_pc);
      #1;
      check({name, "_ack_req"}, mem_req, 1'b1);
      check({name, "_ack_addr"}, mem_addr, exp_pc);
      check({name, "_ack_pc_e"}, pc_e, 1'b1);
      check({name, "_ack_funsel"}, pc_funsel, 2'b01);
      check({name, "_ack_pc_i"}, pc_i, 16'h0000);
      check({name, "_ack_valid"}, instr_valid, 1'b0);
      exp_pc = exp_pc + 16'd1;
    end
    for (int h = 0; h < hold; h++) begin
      cyc();
      mem_ack = 1'b0; instr_ready = 1'b0; start = 1'b1; pc_clr = 1'b1; jump_en = 1'b1;
      #1;
      check({name, "_hold_valid"}, instr_valid, 1'b1);
      check({name, "_hold_pc_e"}, pc_e, 1'b0);
      check({name, "_hold_req"}, mem_req, 1'b0);
      if (sb.size() > 0) check({name, "_hold_stable"}, instr, sb[0]);
    end
    cyc();
    mem_ack = 1'b0; instr_ready = 1'b1; start = next_start; pc_clr = 1'b1; jump_en = 1'b1;
    #1;
    check({name, "_hs_valid"}, instr_valid, 1'b1);
    check({name, "_hs_pc"}, pc_reg, exp_pc);
    check({name, "_sb_nonempty"}, (sb.size() > 0), 1'b1);
    if (sb.size() > 0) check({name, "_instr"}, instr, sb.pop_front());
    if (next_start) push_expected();
  endtask

  typedef struct {
    logic        clr;
    logic        jmp;
    logic        st;
    logic [15:0] addr;
    logic        exp_e;
    logic [1:0]  exp_fs;
    logic        chk_pi;
    logic [15:0] exp_pi;
  } prio_vec_t;

  prio_vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{clr:1'b0, jmp:1'b1, st:1'b0, addr:16'h5A5A, exp_e:1'b1, exp_fs:2'b10, chk_pi:1'b1, exp_pi:16'h5A5A};
    tbl[1] = '{clr:1'b1, jmp:1'b1, st:1'b1, addr:16'hABCD, exp_e:1'b1, exp_fs:2'b11, chk_pi:1'b0, exp_pi:16'h0000};
    tbl[2] = '{clr:1'b0, jmp:1'b1, st:1'b1, addr:16'h0777, exp_e:1'b1, exp_fs:2'b10, chk_pi:1'b1, exp_pi:16'h0777};
    tbl[3] = '{clr:1'b0, jmp:1'b0, st:1'b0, addr:16'h1111, exp_e:1'b0, exp_fs:2'b00, chk_pi:1'b1, exp_pi:16'h0000};
    tbl[4] = '{clr:1'b1, jmp:1'b0, st:1'b0, addr:16'h2222, exp_e:1'b1, exp_fs:2'b11, chk_pi:1'b0, exp_pi:16'h0000};
    tbl[5] = '{clr:1'b0, jmp:1'b1, st:1'b0, addr:16'h0010, exp_e:1'b1, exp_fs:2'b10, chk_pi:1'b1, exp_pi:16'h0010};

    // Reset state, with clear/start requests present that must be masked.
    rst = 1'b0;
    set_idle();
    pc_clr = 1'b1; jump_en = 1'b1; jump_addr = 16'h1234; start = 1'b1;
    #2;
    check("rst_pc_e", pc_e, 1'b0);
    check("rst_funsel", pc_funsel, 2'b00);
    check("rst_pc_i", pc_i, 16'h0000);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_instr", instr, 16'h0000);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    cyc();
    cyc();
    check("rst_pc_untouched", pc_reg, 16'h0000);
    set_idle();
    rst = 1'b1;
    exp_pc = 16'h0000;
    idle_cycle("post_rst");

    // IDLE priority vectors: each row is one request cycle then one quiet cycle.
    for (int i = 0; i < 6; i++) begin
      cyc();
      set_idle();
      pc_clr = tbl[i].clr; jump_en = tbl[i].jmp; start = tbl[i].st; jump_addr = tbl[i].addr;
      #1;
      check($sformatf("prio%0d_pc_e", i), pc_e, tbl[i].exp_e);
      check($sformatf("prio%0d_funsel", i), pc_funsel, tbl[i].exp_fs);
      if (tbl[i].chk_pi) check($sformatf("prio%0d_pc_i", i), pc_i, tbl[i].exp_pi);
      check($sformatf("prio%0d_busy", i), busy, 1'b0);
      if (tbl[i].exp_e && tbl[i].exp_fs == 2'b11) exp_pc = 16'h0000;
      else if (tbl[i].exp_e && tbl[i].exp_fs == 2'b10) exp_pc = tbl[i].addr;
      idle_cycle($sformatf("prio%0d", i));
    end

    // Zero-wait fetch from 0010: expect 1234, PC ends at 0012.
    start_cycle("zw");
    run_word(0, 0, 1'b0, "zw");
    idle_cycle("zw");
    check("zw_instr_1234", instr, 16'h1234);
    check("zw_final_pc", pc_reg, 16'h0012);

    // Three wait states per byte.
    start_cycle("ws");
    run_word(3, 0, 1'b0, "ws");
    idle_cycle("ws");
    check("ws_final_pc", pc_reg, 16'h0014);

    // Back-to-back fetches: second word starts straight from HOLD.
    start_cycle("b2b");
    run_word(0, 1, 1'b1, "b2b_w0");
    run_word(1, 0, 1'b0, "b2b_w1");
    idle_cycle("b2b");
    check("b2b_final_pc", pc_reg, 16'h0018);

    // Jump to FFFF, fetch across the wrap with five cycles of backpressure.
    cyc();
    set_idle();
    jump_en = 1'b1; jump_addr = 16'hFFFF;
    #1;
    check("wrap_jump_funsel", pc_funsel, 2'b10);
    exp_pc = 16'hFFFF;
    start_cycle("wrap");
    run_word(0, 5, 1'b0, "wrap");
    idle_cycle("wrap");
    check("wrap_final_pc", pc_reg, 16'h0001);

    // Reset asserted while in REQ_HI: outputs drop without a clock edge.
    start_cycle("mid");
    cyc();
    mem_ack = 1'b1; mem_rdata = mem_byte(exp_pc); start = 1'b0;
    #1;
    check("mid_lo_funsel", pc_funsel, 2'b01);
    exp_pc = exp_pc + 16'd1;
    cyc();
    mem_ack = 1'b0; pc_clr = 1'b1; jump_en = 1'b1; start = 1'b1;
    #1;
    check("mid_in_req_hi", mem_req, 1'b1);
    rst = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_pc_e", pc_e, 1'b0);
    check("mid_rst_funsel", pc_funsel, 2'b00);
    check("mid_rst_pc_i", pc_i, 16'h0000);
    check("mid_rst_mem_req", mem_req, 1'b0);
    check("mid_rst_mem_addr", mem_addr, 16'h0000);
    check("mid_rst_instr", instr, 16'h0000);
    check("mid_rst_valid", instr_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    cyc();
    #1;
    check("mid_rst_pc_held", pc_reg, exp_pc);
    set_idle();
    rst = 1'b1;
    idle_cycle("mid_after");
    check("mid_after_instr", instr, 16'h0000);

    // Recovery fetch after reset.
    start_cycle("rec");
    run_word(2, 0, 1'b0, "rec");
    idle_cycle("rec");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
